// File: rtl/lcd_write_fsm.sv
// Character writer for a 4-bit HD44780 bus: per character, Set-DDRAM-address then the data byte.
// Build option LCD_FRAME_CLEAR_EN: a Clear Display command precedes the character at addr 0 / memory_addr 0.
module lcd_write_fsm #(
    parameter int T_SETUP    = 2,
    parameter int T_EPULSE   = 12,
    parameter int T_HOLD     = 1,
    parameter int T_NIB_GAP  = 50,
    parameter int T_BYTE_GAP = 2000
`ifdef LCD_FRAME_CLEAR_EN
    ,
    parameter int T_CLEAR    = 82000
`endif
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [6:0]  i_addr,
    input  logic [10:0] i_memory_addr,
    input  logic [7:0]  i_char_data,
    output logic        o_change_addr,
    output logic        o_change_memory_addr,
    output logic        o_lcd_e,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [3:0]  o_sf_d,
    output logic        o_busy,
    output logic [3:0]  o_state
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_LOAD, ST_N_SETUP, ST_N_E, ST_N_HOLD,
        ST_N_GAP, ST_B_GAP, ST_ADVANCE, ST_CLR_WAIT
    } state_t;
    typedef enum logic [1:0] {PH_CMD, PH_DATA, PH_CLEAR} phase_t;

    // Timers load with duration-1 so each state lasts exactly its duration.
    localparam logic [16:0] LD_SETUP  = 17'(T_SETUP - 1);
    localparam logic [16:0] LD_EPULSE = 17'(T_EPULSE - 1);
    localparam logic [16:0] LD_HOLD   = 17'(T_HOLD - 1);
    localparam logic [16:0] LD_NIBGAP = 17'(T_NIB_GAP - 1);
    localparam logic [16:0] LD_BYTGAP = 17'(T_BYTE_GAP - 1);
`ifdef LCD_FRAME_CLEAR_EN
    localparam logic [16:0] LD_CLEAR  = 17'(T_CLEAR - 1);
`endif

    state_t      r_state, w_state_nx;
    phase_t      r_phase, w_phase_nx;
    logic [16:0] r_timer, w_timer_nx;
    logic [7:0]  r_byte, w_byte_nx;
    logic        r_lower, w_lower_nx;
    logic        r_lcd_rs, w_lcd_rs_nx;
    logic [3:0]  r_sf_d, w_sf_d_nx;
    logic        w_timer_done;

    assign w_timer_done = (r_timer == 17'd0);

`ifndef LCD_FRAME_CLEAR_EN
    logic w_unused_mem;
    assign w_unused_mem = ^i_memory_addr;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_phase  <= PH_CMD;
            r_timer  <= '0;
            r_byte   <= '0;
            r_lower  <= 1'b0;
            r_lcd_rs <= 1'b0;
            r_sf_d   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_phase  <= w_phase_nx;
            r_timer  <= w_timer_nx;
            r_byte   <= w_byte_nx;
            r_lower  <= w_lower_nx;
            r_lcd_rs <= w_lcd_rs_nx;
            r_sf_d   <= w_sf_d_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_phase_nx  = r_phase;
        w_timer_nx  = r_timer;
        w_byte_nx   = r_byte;
        w_lower_nx  = r_lower;
        w_lcd_rs_nx = r_lcd_rs;
        w_sf_d_nx   = r_sf_d;
        if (i_start && r_state != ST_IDLE) begin
            // Init phase reclaims the bus: drop everything, no change pulse.
            w_state_nx = ST_IDLE;
            w_timer_nx = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!i_start) w_state_nx = ST_LOAD;
                end
                ST_LOAD: begin
                    w_byte_nx  = {1'b1, i_addr};
                    w_phase_nx = PH_CMD;
`ifdef LCD_FRAME_CLEAR_EN
                    if (i_addr == 7'd0 && i_memory_addr == 11'd0) begin
                        w_byte_nx  = 8'h01;
                        w_phase_nx = PH_CLEAR;
                    end
`endif
                    w_lcd_rs_nx = 1'b0;
                    w_sf_d_nx   = w_byte_nx[7:4];
                    w_lower_nx  = 1'b0;
                    w_timer_nx  = LD_SETUP;
                    w_state_nx  = ST_N_SETUP;
                end
                ST_N_SETUP: begin
                    if (w_timer_done) begin
                        w_state_nx = ST_N_E;
                        w_timer_nx = LD_EPULSE;
                    end else w_timer_nx = r_timer - 17'd1;
                end
                ST_N_E: begin
                    if (w_timer_done) begin
                        w_state_nx = ST_N_HOLD;
                        w_timer_nx = LD_HOLD;
                    end else w_timer_nx = r_timer - 17'd1;
                end
                ST_N_HOLD: begin
                    if (!w_timer_done) w_timer_nx = r_timer - 17'd1;
                    else if (!r_lower) begin
                        w_state_nx = ST_N_GAP;
                        w_timer_nx = LD_NIBGAP;
                    end else begin
                        w_state_nx = ST_B_GAP;
                        w_timer_nx = LD_BYTGAP;
                    end
                end
                ST_N_GAP: begin
                    if (w_timer_done) begin
                        w_lower_nx = 1'b1;
                        w_sf_d_nx  = r_byte[3:0];
                        w_timer_nx = LD_SETUP;
                        w_state_nx = ST_N_SETUP;
                    end else w_timer_nx = r_timer - 17'd1;
                end
                ST_B_GAP: begin
                    if (!w_timer_done) w_timer_nx = r_timer - 17'd1;
                    else if (r_phase == PH_DATA) w_state_nx = ST_ADVANCE;
`ifdef LCD_FRAME_CLEAR_EN
                    else if (r_phase == PH_CLEAR) begin
                        w_state_nx = ST_CLR_WAIT;
                        w_timer_nx = LD_CLEAR;
                    end
`endif
                    else begin
                        // The only point where char_data is sampled for this character.
                        w_byte_nx   = i_char_data;
                        w_phase_nx  = PH_DATA;
                        w_lcd_rs_nx = 1'b1;
                        w_sf_d_nx   = i_char_data[7:4];
                        w_lower_nx  = 1'b0;
                        w_timer_nx  = LD_SETUP;
                        w_state_nx  = ST_N_SETUP;
                    end
                end
`ifdef LCD_FRAME_CLEAR_EN
                ST_CLR_WAIT: begin
                    if (w_timer_done) begin
                        w_byte_nx   = {1'b1, i_addr};
                        w_phase_nx  = PH_CMD;
                        w_lcd_rs_nx = 1'b0;
                        w_sf_d_nx   = {1'b1, i_addr[6:4]};
                        w_lower_nx  = 1'b0;
                        w_timer_nx  = LD_SETUP;
                        w_state_nx  = ST_N_SETUP;
                    end else w_timer_nx = r_timer - 17'd1;
                end
`endif
                ST_ADVANCE: w_state_nx = ST_LOAD;
                default:    w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign o_lcd_e              = (r_state == ST_N_E);
    assign o_lcd_rs             = r_lcd_rs;
    assign o_lcd_rw             = 1'b0;
    assign o_sf_d               = r_sf_d;
    assign o_change_addr        = (r_state == ST_ADVANCE);
    assign o_change_memory_addr = (r_state == ST_ADVANCE);
    assign o_busy               = (r_state != ST_IDLE);
    assign o_state              = r_state;
endmodule

// File: tb/tb_lcd_write_fsm.sv
// Self-checking bench for lcd_write_fsm: a bus monitor records every lcd_e strobe and change pulse,
// and each test compares them against nibble sequences and cycle counts derived from the timing rules.
module tb_lcd_write_fsm;
  localparam int T_SETUP    = 2;
  localparam int T_EPULSE   = 12;
  localparam int T_HOLD     = 1;
  localparam int T_NIB_GAP  = 50;
  localparam int T_BYTE_GAP = 2000;
  localparam int T_CLEAR    = 82000;
  localparam int BYTE_CYC   = 2 * (T_SETUP + T_EPULSE + T_HOLD) + T_NIB_GAP + T_BYTE_GAP;
  localparam int CHAR_CYC   = 1 + 2 * BYTE_CYC + 1;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [6:0]  i_addr;
  logic [10:0] i_memory_addr;
  logic [7:0]  i_char_data;
  logic        o_change_addr, o_change_memory_addr, o_lcd_e, o_lcd_rs, o_lcd_rw, o_busy;
  logic [3:0]  o_sf_d, o_state;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_write_fsm dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_addr(i_addr),
    .i_memory_addr(i_memory_addr), .i_char_data(i_char_data),
    .o_change_addr(o_change_addr), .o_change_memory_addr(o_change_memory_addr),
    .o_lcd_e(o_lcd_e), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_sf_d(o_sf_d),
    .o_busy(o_busy), .o_state(o_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bus monitor ----------------
  typedef struct {
    logic       rs;
    logic [3:0] d;
    int         width;
    int         setup;
    int         rise;
  } nib_t;

  nib_t       nib_q[$];
  int         pulse_q[$];
  logic [4:0] exp_q[$];
  nib_t       cur;
  int         bus_glitch = 0, rw_err = 0, coinc_err = 0, e_rises = 0, last_chg = 0;
  logic       prev_e = 1'b0, prev_rs = 1'b0;
  logic [3:0] prev_d = 4'h0;

  always @(negedge clk) begin
    if (o_sf_d !== prev_d || o_lcd_rs !== prev_rs) begin
      last_chg = cyc;
      if (o_lcd_e === 1'b1 && prev_e) bus_glitch++;
    end
    if (o_lcd_e === 1'b1 && !prev_e) begin
      cur.rs = o_lcd_rs; cur.d = o_sf_d; cur.rise = cyc; cur.setup = cyc - last_chg;
      e_rises++;
    end
    if (o_lcd_e !== 1'b1 && prev_e) begin
      cur.width = cyc - cur.rise;
      nib_q.push_back(cur);
    end
    if (o_change_addr === 1'b1) pulse_q.push_back(cyc);
    if (o_change_addr !== o_change_memory_addr) coinc_err++;
    if (o_lcd_rw !== 1'b0) rw_err++;
    prev_e  = (o_lcd_e === 1'b1);
    prev_rs = o_lcd_rs;
    prev_d  = o_sf_d;
  end

  // ---------------- reference model / driver helpers ----------------
  task automatic model_char(input logic [6:0] a, input logic [7:0] c, input bit clr);
    logic [7:0] cmd;
    cmd = {1'b1, a};
    if (clr) begin
      exp_q.push_back({1'b0, 4'h0});
      exp_q.push_back({1'b0, 4'h1});
    end
    exp_q.push_back({1'b0, cmd[7:4]});
    exp_q.push_back({1'b0, cmd[3:0]});
    exp_q.push_back({1'b1, c[7:4]});
    exp_q.push_back({1'b1, c[3:0]});
  endtask

  function automatic logic [6:0] rnd_addr();
    int r;
    r = $urandom_range(0, 31);
    return (r < 16) ? 7'(r) : 7'(r + 48);
  endfunction

  task automatic go_idle();
    i_start = 1'b1;
    repeat (3) @(negedge clk);
    nib_q.delete();
    pulse_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit got;
    int rises0;
    i_reset = 1'b0; i_start = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({o_lcd_e, o_lcd_rs, o_lcd_rw, o_sf_d, o_change_addr, o_change_memory_addr, o_busy} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got e=%b rs=%b rw=%b d=%h ca=%b cma=%b busy=%b expected all 0",
               o_lcd_e, o_lcd_rs, o_lcd_rw, o_sf_d, o_change_addr, o_change_memory_addr, o_busy);
    end
    i_reset = 1'b1; i_start = 1'b0; i_addr = 7'd3; i_memory_addr = 11'd9; i_char_data = 8'h5a;
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (o_lcd_e === 1'b1) got = 1;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL reset_pre_strobe got no lcd_e within 50 cycles expected one"); end
    #2 i_reset = 1'b0;
    #1;
    n_tests++;
    if ({o_lcd_e, o_lcd_rs, o_sf_d, o_change_addr, o_busy} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async got e=%b rs=%b d=%h ca=%b busy=%b expected all 0",
               o_lcd_e, o_lcd_rs, o_sf_d, o_change_addr, o_busy);
    end
    @(negedge clk);
    i_start = 1'b1;
    i_reset = 1'b1;
    rises0 = e_rises;
    repeat (200) @(negedge clk);
    n_tests++;
    if (o_busy !== 1'b0 || e_rises != rises0) begin
      n_fail++;
      $display("FAIL reset_release_idle got busy=%b new_strobes=%0d expected busy=0 strobes=0",
               o_busy, e_rises - rises0);
    end
  endtask

  task automatic test_char_write();
    bit   got;
    int   load;
    nib_t nb;
    logic [4:0] ex;
    go_idle();
    i_addr = 7'd0; i_memory_addr = 11'd5; i_char_data = 8'h41;
    model_char(7'd0, 8'h41, 0);
    model_char(7'd0, 8'h41, 0);
    load = cyc + 1;
    i_start = 1'b0;
    got = 0;
    for (int t = 0; t < 2 * CHAR_CYC + 100 && !got; t++) begin
      @(negedge clk);
      if (pulse_q.size() >= 2) got = 1;
    end
    i_start = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL char_pulses got %0d pulses expected 2", pulse_q.size());
    end else begin
      if (pulse_q[0] != load + CHAR_CYC - 1) begin
        n_fail++;
        $display("FAIL char_first_pulse got cycle %0d expected %0d", pulse_q[0], load + CHAR_CYC - 1);
      end
      n_tests++;
      if (pulse_q[1] - pulse_q[0] != CHAR_CYC) begin
        n_fail++;
        $display("FAIL char_pulse_period got %0d expected %0d", pulse_q[1] - pulse_q[0], CHAR_CYC);
      end
    end
    n_tests++;
    if (nib_q.size() < 3) begin
      n_fail++;
      $display("FAIL char_strobe_count got %0d expected >=3", nib_q.size());
    end else begin
      if (nib_q[0].rise != load + 1 + T_SETUP) begin
        n_fail++;
        $display("FAIL char_first_strobe got cycle %0d expected %0d", nib_q[0].rise, load + 1 + T_SETUP);
      end
      n_tests++;
      if (nib_q[1].rise - nib_q[0].rise != T_EPULSE + T_HOLD + T_NIB_GAP + T_SETUP) begin
        n_fail++;
        $display("FAIL char_nibble_spacing got %0d expected %0d", nib_q[1].rise - nib_q[0].rise,
                 T_EPULSE + T_HOLD + T_NIB_GAP + T_SETUP);
      end
      n_tests++;
      if (nib_q[2].rise - nib_q[0].rise != BYTE_CYC) begin
        n_fail++;
        $display("FAIL char_byte_spacing got %0d expected %0d", nib_q[2].rise - nib_q[0].rise, BYTE_CYC);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      ex = exp_q.pop_front();
      if (nib_q.size() == 0) begin
        n_fail++;
        $display("FAIL char_nibble%0d got none expected rs/d=%h", i, ex);
      end else begin
        nb = nib_q.pop_front();
        if ({nb.rs, nb.d} !== ex) begin
          n_fail++;
          $display("FAIL char_nibble%0d got rs/d=%h expected %h", i, {nb.rs, nb.d}, ex);
        end
        n_tests++;
        if (nb.width != T_EPULSE || nb.setup < T_SETUP) begin
          n_fail++;
          $display("FAIL char_strobe%0d got width=%0d setup=%0d expected width=%0d setup>=%0d",
                   i, nb.width, nb.setup, T_EPULSE, T_SETUP);
        end
      end
    end
  endtask

  task automatic test_addr_cmd();
    logic [6:0] alist[3];
    logic [7:0] cmd;
    bit   got;
    nib_t nb;
    alist[0] = 7'd64; alist[1] = 7'd79; alist[2] = rnd_addr();
    for (int k = 0; k < 3; k++) begin
      go_idle();
      i_addr = alist[k]; i_memory_addr = 11'd7; i_char_data = 8'h20;
      cmd = {1'b1, alist[k]};
      i_start = 1'b0;
      got = 0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        if (nib_q.size() >= 2) got = 1;
      end
      i_start = 1'b1;
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL addr_cmd addr=%0d got %0d strobes expected 2", alist[k], nib_q.size());
      end else begin
        nb = nib_q[0];
        if ({nb.rs, nb.d} !== {1'b0, cmd[7:4]}) begin
          n_fail++;
          $display("FAIL addr_cmd_hi addr=%0d got rs/d=%h expected %h", alist[k], {nb.rs, nb.d}, {1'b0, cmd[7:4]});
        end
        n_tests++;
        nb = nib_q[1];
        if ({nb.rs, nb.d} !== {1'b0, cmd[3:0]}) begin
          n_fail++;
          $display("FAIL addr_cmd_lo addr=%0d got rs/d=%h expected %h", alist[k], {nb.rs, nb.d}, {1'b0, cmd[3:0]});
        end
      end
    end
  endtask

  task automatic test_char_sample();
    bit   got;
    int   load;
    logic [6:0] a;
    logic [7:0] c;
    nib_t nb;
    logic [4:0] ex;
    go_idle();
    a = rnd_addr(); c = 8'($urandom_range(0, 255));
    i_addr = a; i_char_data = c; i_memory_addr = 11'($urandom_range(1, 2047));
    model_char(a, c, 0);
    load = cyc + 1;
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (BYTE_CYC + 1) @(negedge clk);
      got = 0;
      for (int t = 0; t < BYTE_CYC + 100 && !got; t++) begin
        @(negedge clk);
        if (o_change_addr === 1'b1) got = 1;
        else i_char_data = 8'($urandom_range(0, 255));
      end
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL sample_pulse char%0d got no pulse expected cycle %0d", k, load + CHAR_CYC - 1);
        break;
      end else if (cyc != load + CHAR_CYC - 1) begin
        n_fail++;
        $display("FAIL sample_pulse char%0d got cycle %0d expected %0d", k, cyc, load + CHAR_CYC - 1);
      end
      if (k < 2) begin
        a = rnd_addr(); c = 8'($urandom_range(0, 255));
        i_addr = a; i_char_data = c; i_memory_addr = 11'($urandom_range(1, 2047));
        model_char(a, c, 0);
        load = cyc + 1;
      end
    end
    i_start = 1'b1;
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_tests++;
      ex = exp_q.pop_front();
      if (nib_q.size() == 0) begin
        n_fail++;
        $display("FAIL sample_nibble got none expected rs/d=%h", ex);
      end else begin
        nb = nib_q.pop_front();
        if ({nb.rs, nb.d} !== ex || nb.width != T_EPULSE) begin
          n_fail++;
          $display("FAIL sample_nibble got rs/d=%h width=%0d expected rs/d=%h width=%0d",
                   {nb.rs, nb.d}, nb.width, ex, T_EPULSE);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit got;
    go_idle();
    i_addr = rnd_addr(); i_memory_addr = 11'd3; i_char_data = 8'h33;
    i_start = 1'b0;
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (o_lcd_e === 1'b1) got = 1;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL abort_pre_strobe got no lcd_e expected one"); end
    repeat ($urandom_range(0, 9)) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_lcd_e !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_cycle got e=%b busy=%b expected e=0 busy=0", o_lcd_e, o_busy);
    end
    repeat (CHAR_CYC + 10) @(negedge clk);
    n_tests++;
    if (pulse_q.size() != 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_pulse got pulses=%0d busy=%b expected 0 and 0", pulse_q.size(), o_busy);
    end
  endtask

`ifdef LCD_FRAME_CLEAR_EN
  task automatic test_clear();
    bit   got;
    int   load;
    nib_t nb;
    logic [4:0] ex;
    go_idle();
    i_addr = 7'd0; i_memory_addr = 11'd0; i_char_data = 8'h48;
    model_char(7'd0, 8'h48, 1);
    load = cyc + 1;
    i_start = 1'b0;
    got = 0;
    for (int t = 0; t < CHAR_CYC + BYTE_CYC + T_CLEAR + 100 && !got; t++) begin
      @(negedge clk);
      if (o_change_addr === 1'b1) got = 1;
    end
    n_tests++;
    if (!got || cyc != load + CHAR_CYC + BYTE_CYC + T_CLEAR - 1) begin
      n_fail++;
      $display("FAIL clear_first_pulse got cycle %0d (seen=%0d) expected %0d", cyc, got,
               load + CHAR_CYC + BYTE_CYC + T_CLEAR - 1);
    end
    load = cyc;
    i_addr = 7'd1; i_memory_addr = 11'd1;
    model_char(7'd1, 8'h48, 0);
    got = 0;
    for (int t = 0; t < CHAR_CYC + 100 && !got; t++) begin
      @(negedge clk);
      if (o_change_addr === 1'b1) got = 1;
    end
    i_start = 1'b1;
    n_tests++;
    if (!got || cyc - load != CHAR_CYC) begin
      n_fail++;
      $display("FAIL clear_second_period got %0d (seen=%0d) expected %0d", cyc - load, got, CHAR_CYC);
    end
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_tests++;
      ex = exp_q.pop_front();
      if (nib_q.size() == 0) begin
        n_fail++;
        $display("FAIL clear_nibble got none expected rs/d=%h", ex);
      end else begin
        nb = nib_q.pop_front();
        if ({nb.rs, nb.d} !== ex) begin
          n_fail++;
          $display("FAIL clear_nibble got rs/d=%h expected %h", {nb.rs, nb.d}, ex);
        end
      end
    end
  endtask
`endif

  task automatic test_bus_rules();
    n_tests++;
    if (bus_glitch != 0) begin
      n_fail++;
      $display("FAIL bus_stable_during_e got %0d changes expected 0", bus_glitch);
    end
    n_tests++;
    if (rw_err != 0) begin
      n_fail++;
      $display("FAIL lcd_rw_zero got %0d nonzero samples expected 0", rw_err);
    end
    n_tests++;
    if (coinc_err != 0) begin
      n_fail++;
      $display("FAIL pulses_coincident got %0d differing samples expected 0", coinc_err);
    end
  endtask

  initial begin
    i_reset = 1'b0; i_start = 1'b1; i_addr = '0; i_memory_addr = '0; i_char_data = '0;
    test_reset();
    test_char_write();
    test_addr_cmd();
    test_char_sample();
    test_abort();
`ifdef LCD_FRAME_CLEAR_EN
    test_clear();
`endif
    test_bus_rules();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
